exe_dispatch_fsm: RTL and testbench

- Next-generation execution control FSM for the Theia core.
- Sits between the instruction decode unit and a pipelined ALU; keeps up to DEPTH operations in flight instead of one.
- Tracks each in-flight op's opcode and destination in an in-order tag FIFO, drives RAM write-back, and squashes younger ops after a taken branch.
- Generalised over lane count (LANES) and pipeline depth (DEPTH).

---
 rtl/exe_pkg.sv | 23 ++
 rtl/exe_tag_fifo.sv | 100 ++++++++++
 rtl/exe_dispatch_fsm.sv | 156 +++++++++++++++
 tb/tb_exe_dispatch_fsm.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the Theia execution dispatch block: opcode
// constants, the in-flight tag entry layout and the control FSM encoding.
package exe_pkg;

   localparam int TAG_OP_W   = 16;
   localparam int TAG_ADDR_W = 16;

   localparam logic [TAG_OP_W-1:0] NOP = 16'h0000;
   localparam logic [TAG_OP_W-1:0] RET = 16'h000C;

   typedef struct packed {
      logic [TAG_OP_W-1:0]   op;
      logic [TAG_ADDR_W-1:0] dest;
      logic                  squash;
   } tag_entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FLUSH  = 2'd2
   } state_t;

endpackage

// File: rtl/exe_tag_fifo.sv
// In-order tag FIFO holding {op, dest, squash} for every op in flight.
// squash_all marks every stored entry (and a same-cycle push) as squashed.
// Optional macro EXE_SCOREBOARD_EN adds a parallel destination compare.
module exe_tag_fifo
   import exe_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [TAG_OP_W-1:0]   push_op,
   input  logic [TAG_ADDR_W-1:0] push_dest,
   input  logic                  pop,
   input  logic                  squash_all,
   output tag_entry_t            head,
   output logic [CNT_W-1:0]      count
`ifdef EXE_SCOREBOARD_EN
   ,
   input  logic [TAG_ADDR_W-1:0] cmp_addr0,
   input  logic [TAG_ADDR_W-1:0] cmp_addr1,
   output logic                  hit
`endif
);

   logic [TAG_OP_W-1:0]   op_mem   [DEPTH];
   logic [TAG_ADDR_W-1:0] dest_mem [DEPTH];
   logic [DEPTH-1:0]      squash_q, squash_n;
   logic [DEPTH-1:0]      valid_q, valid_n;
   logic [PTR_W-1:0]      rd_ptr, wr_ptr;
   logic                  do_pop;

   // A pop against an empty FIFO is dropped here; the top flags it.
   assign do_pop = pop && (count != '0);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + 1'b1;
   endfunction

   // Head entry as seen by the write-back / branch logic this cycle.
   always_comb begin
      head.op     = op_mem[rd_ptr];
      head.dest   = dest_mem[rd_ptr];
      head.squash = squash_q[rd_ptr];
   end

   // Per-slot valid/squash update; the pushed entry inherits squash_all.
   always_comb begin
      valid_n  = valid_q;
      squash_n = squash_q;
      if (do_pop) valid_n[rd_ptr] = 1'b0;
      if (squash_all) squash_n = '1;
      if (push) begin
         valid_n[wr_ptr]  = 1'b1;
         squash_n[wr_ptr] = squash_all;
      end
   end

   // Payload storage, written on push only.
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr]   <= push_op;
         dest_mem[wr_ptr] <= push_dest;
      end
   end

   // Pointers, occupancy and per-slot flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         valid_q  <= '0;
         squash_q <= '0;
      end else begin
         if (push)   wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         count    <= count + CNT_W'(push) - CNT_W'(do_pop);
         valid_q  <= valid_n;
         squash_q <= squash_n;
      end
   end

`ifdef EXE_SCOREBOARD_EN
   // RAW check: any live, non-squashed, non-NOP entry writing a source.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && !squash_q[i] && (op_mem[i] != NOP) &&
             ((dest_mem[i] == cmp_addr0) || (dest_mem[i] == cmp_addr1)))
            hit = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/exe_dispatch_fsm.sv
// Theia execution dispatch: issues decoded ops to a pipelined ALU, keeps up
// to DEPTH ops in flight in an in-order tag FIFO, writes results back and
// squashes younger ops after a taken branch.
// Optional macro EXE_SCOREBOARD_EN adds iSrcAddr0/iSrcAddr1 and oHazard
// for a RAW-hazard stall on oReady.
module exe_dispatch_fsm
   import exe_pkg::*;
#(
   parameter int LANES  = 3,
   parameter int LANE_W = 32,
   parameter int OP_W   = TAG_OP_W,
   parameter int ADDR_W = TAG_ADDR_W,
   parameter int ROM_W  = 16,
   parameter int DEPTH  = 4
)
(
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    iDecodeDone,
   output logic                    oReady,
   input  logic [OP_W-1:0]         iOperation,
   input  logic [LANES*LANE_W-1:0] iSource0,
   input  logic [LANES*LANE_W-1:0] iSource1,
   input  logic [ADDR_W-1:0]       iDestination,
   output logic                    oTriggerALU,
   output logic [OP_W-1:0]         oALUOperation,
   output logic [LANES*LANE_W-1:0] oALUChannelA,
   output logic [LANES*LANE_W-1:0] oALUChannelB,
   input  logic                    iALUOutputReady,
   input  logic [LANES*LANE_W-1:0] iALUResult,
   input  logic                    iBranchTaken,
   input  logic                    iBranchNotTaken,
   output logic                    oRAMWriteEnable,
   output logic [ADDR_W-1:0]       oRAMWriteAddress,
   output logic [LANES*LANE_W-1:0] oRAMWriteData,
   output logic                    oJumpFlag,
   output logic [ROM_W-1:0]        oJumpIp,
   output logic [ADDR_W-1:0]       oLastDestination,
   output logic                    oBusy,
   output logic                    oProtocolError
`ifdef EXE_SCOREBOARD_EN
   ,
   input  logic [ADDR_W-1:0]       iSrcAddr0,
   input  logic [ADDR_W-1:0]       iSrcAddr1,
   output logic                    oHazard
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   state_t           state, state_n;
   tag_entry_t       head;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] remaining;
   logic             accept, pop_valid, jump, hazard;

`ifdef EXE_SCOREBOARD_EN
   exe_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (Clock),
      .rst        (Reset),
      .push       (accept),
      .push_op    (TAG_OP_W'(iOperation)),
      .push_dest  (TAG_ADDR_W'(iDestination)),
      .pop        (iALUOutputReady),
      .squash_all (jump),
      .head       (head),
      .count      (count),
      .cmp_addr0  (TAG_ADDR_W'(iSrcAddr0)),
      .cmp_addr1  (TAG_ADDR_W'(iSrcAddr1)),
      .hit        (hazard)
   );
   assign oHazard = hazard;
`else
   exe_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (Clock),
      .rst        (Reset),
      .push       (accept),
      .push_op    (TAG_OP_W'(iOperation)),
      .push_dest  (TAG_ADDR_W'(iDestination)),
      .pop        (iALUOutputReady),
      .squash_all (jump),
      .head       (head),
      .count      (count)
   );
   assign hazard = 1'b0;
`endif

   // Ready depends only on registered occupancy/state (plus the optional
   // source compare), never on this cycle's branch outcome.
   assign oReady    = (count < CNT_W'(DEPTH)) && (state != FLUSH) && !hazard;
   assign accept    = iDecodeDone && oReady;
   assign pop_valid = iALUOutputReady && (count != '0);
   assign jump      = pop_valid && iBranchTaken && !head.squash;
   assign oBusy     = (state != IDLE);

   // Next state plus all combinational issue / write-back / redirect outputs.
   always_comb begin
      state_n          = state;
      oTriggerALU      = accept;
      oALUOperation    = '0;
      oALUChannelA     = '0;
      oALUChannelB     = '0;
      oRAMWriteEnable  = 1'b0;
      oRAMWriteAddress = '0;
      oRAMWriteData    = '0;
      oJumpFlag        = jump;
      oJumpIp          = '0;
      remaining        = count + CNT_W'(accept) - CNT_W'(pop_valid);

      if (accept) begin
         oALUOperation = iOperation;
         oALUChannelA  = iSource1;
         oALUChannelB  = iSource0;
      end

      if (count != '0) begin
         oRAMWriteAddress = ADDR_W'(head.dest);
         oJumpIp          = ROM_W'(head.dest);
      end

      if (pop_valid) begin
         oRAMWriteData   = iALUResult;
         oRAMWriteEnable = !head.squash && (head.op != NOP) &&
                           (!(iBranchTaken || iBranchNotTaken) || (head.op == RET));
      end

      case (state)
         IDLE:    if (accept) state_n = ACTIVE;
         ACTIVE: begin
            if (jump)                 state_n = (remaining != '0) ? FLUSH : IDLE;
            else if (remaining == '0) state_n = IDLE;
         end
         FLUSH:   if (remaining == '0) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_n;
   end

   // Forwarding register: destination of the most recently accepted op.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)       oLastDestination <= '0;
      else if (accept) oLastDestination <= iDestination;
   end

   // Sticky flag for a result that arrives with nothing in flight.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)                                    oProtocolError <= 1'b0;
      else if (iALUOutputReady && (count == '0))    oProtocolError <= 1'b1;
   end

endmodule

// File: tb/tb_exe_dispatch_fsm.sv
// Scoreboard bench for exe_dispatch_fsm. The bench plays the ALU: accepted
// ops are queued with a result and a branch outcome; a monitor retires them
// against a queue-based model of the in-flight window.
module tb_exe_dispatch_fsm;
   import exe_pkg::*;

   localparam int LANES = 3, LANE_W = 32, VW = LANES * LANE_W;
   localparam int OP_W = 16, ADDR_W = 16, ROM_W = 16, DEPTH = 4;
   localparam logic [15:0] ADD = 16'h0001, JMP = 16'h0002;
   localparam int BR_NONE = 0, BR_T = 1, BR_NT = 2;

   logic              Clock = 1'b0, Reset = 1'b1;
   logic              iDecodeDone = 1'b0, oReady, oTriggerALU;
   logic [OP_W-1:0]   iOperation = '0, oALUOperation;
   logic [VW-1:0]     iSource0 = '0, iSource1 = '0, oALUChannelA, oALUChannelB;
   logic [ADDR_W-1:0] iDestination = '0, oRAMWriteAddress, oLastDestination;
   logic              iALUOutputReady = 1'b0, iBranchTaken = 1'b0, iBranchNotTaken = 1'b0;
   logic [VW-1:0]     iALUResult = '0, oRAMWriteData;
   logic              oRAMWriteEnable, oJumpFlag, oBusy, oProtocolError;
   logic [ROM_W-1:0]  oJumpIp;
`ifdef EXE_SCOREBOARD_EN
   logic [ADDR_W-1:0] iSrcAddr0 = '0, iSrcAddr1 = '0;
   logic              oHazard;
`endif

   exe_dispatch_fsm #(.LANES(LANES), .LANE_W(LANE_W), .OP_W(OP_W), .ADDR_W(ADDR_W),
                      .ROM_W(ROM_W), .DEPTH(DEPTH)) dut (
      .Clock(Clock), .Reset(Reset), .iDecodeDone(iDecodeDone), .oReady(oReady),
      .iOperation(iOperation), .iSource0(iSource0), .iSource1(iSource1),
      .iDestination(iDestination), .oTriggerALU(oTriggerALU), .oALUOperation(oALUOperation),
      .oALUChannelA(oALUChannelA), .oALUChannelB(oALUChannelB),
      .iALUOutputReady(iALUOutputReady), .iALUResult(iALUResult),
      .iBranchTaken(iBranchTaken), .iBranchNotTaken(iBranchNotTaken),
      .oRAMWriteEnable(oRAMWriteEnable), .oRAMWriteAddress(oRAMWriteAddress),
      .oRAMWriteData(oRAMWriteData), .oJumpFlag(oJumpFlag), .oJumpIp(oJumpIp),
      .oLastDestination(oLastDestination), .oBusy(oBusy), .oProtocolError(oProtocolError)
`ifdef EXE_SCOREBOARD_EN
      , .iSrcAddr0(iSrcAddr0), .iSrcAddr1(iSrcAddr1), .oHazard(oHazard)
`endif
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int          seq;
      logic [15:0] op;
      logic [15:0] dest;
      logic [VW-1:0] data;
      int          br;
   } exp_t;

   typedef struct {
      logic [VW-1:0] data;
      int            br;
      int            due;
   } alu_t;

   exp_t  exp_q[$];
   alu_t  alu_q[$];
   exp_t  e_new, e_ret;
   alu_t  a_new, a_out;

   int checks = 0, failures = 0;
   int cyc = 0, seq_ctr = 0, squash_upto = 0;
   int drv_br = BR_NONE, drv_lat = 1, stall_pct = 0;
   logic alu_en = 1'b0, stray = 1'b0;
   logic m_flush = 1'b0, m_err = 1'b0;
   logic [15:0] m_last = '0;
   logic exp_ready, haz, sq, exp_we, exp_jmp;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [VW-1:0] lane_sum(input logic [VW-1:0] a, input logic [VW-1:0] b);
      logic [VW-1:0] r;
      for (int l = 0; l < LANES; l++)
         r[l*LANE_W +: LANE_W] = a[l*LANE_W +: LANE_W] + b[l*LANE_W +: LANE_W];
      return r;
   endfunction

   // ALU model: returns queued results in order once their latency elapses.
   always @(posedge Clock) begin
      cyc++;
      #1;
      iALUOutputReady = 1'b0;
      iBranchTaken    = 1'b0;
      iBranchNotTaken = 1'b0;
      iALUResult      = '0;
      if (stray) begin
         iALUOutputReady = 1'b1;
         iBranchTaken    = 1'b1;
         iALUResult      = {3{$urandom}};
      end else if (alu_en && !Reset && alu_q.size() != 0 && alu_q[0].due <= cyc &&
                   $urandom_range(0, 99) >= stall_pct) begin
         a_out           = alu_q.pop_front();
         iALUOutputReady = 1'b1;
         iALUResult      = a_out.data;
         iBranchTaken    = (a_out.br == BR_T);
         iBranchNotTaken = (a_out.br == BR_NT);
      end
   end

   // Monitor: model of the in-flight window, checked every cycle.
   always @(negedge Clock) begin
      if (Reset) begin
         exp_q.delete();
         alu_q.delete();
         m_flush = 1'b0;
         m_last  = '0;
         m_err   = 1'b0;
         chk("rst_busy", oBusy, 0);
         chk("rst_ready", oReady, 1);
         chk("rst_last_dest", oLastDestination, 0);
         chk("rst_proto_err", oProtocolError, 0);
         chk("rst_we", oRAMWriteEnable, 0);
      end else begin
         haz = 1'b0;
`ifdef EXE_SCOREBOARD_EN
         foreach (exp_q[i])
            if (exp_q[i].seq > squash_upto && exp_q[i].op != NOP &&
                (exp_q[i].dest == iSrcAddr0 || exp_q[i].dest == iSrcAddr1))
               haz = 1'b1;
         chk("hazard", oHazard, haz);
`endif
         exp_ready = (exp_q.size() < DEPTH) && !m_flush && !haz;
         chk("ready", oReady, exp_ready);
         chk("busy", oBusy, exp_q.size() != 0);
         chk("last_dest", oLastDestination, m_last);
         chk("proto_err", oProtocolError, m_err);
         chk("trigger", oTriggerALU, iDecodeDone && exp_ready);

         if (iDecodeDone && exp_ready) begin
            chk("alu_op", oALUOperation, iOperation);
            chk("alu_chan_a", oALUChannelA, iSource1);
            chk("alu_chan_b", oALUChannelB, iSource0);
            seq_ctr++;
            e_new.seq  = seq_ctr;
            e_new.op   = iOperation;
            e_new.dest = iDestination;
            e_new.data = lane_sum(iSource1, iSource0);
            e_new.br   = drv_br;
            exp_q.push_back(e_new);
            a_new.data = e_new.data;
            a_new.br   = drv_br;
            a_new.due  = cyc + drv_lat;
            alu_q.push_back(a_new);
            m_last = iDestination;
         end

         if (iALUOutputReady) begin
            if (exp_q.size() == 0) begin
               chk("empty_pop_we", oRAMWriteEnable, 0);
               chk("empty_pop_jump", oJumpFlag, 0);
               m_err = 1'b1;
            end else begin
               e_ret   = exp_q.pop_front();
               sq      = (e_ret.seq <= squash_upto);
               exp_we  = !sq && e_ret.op != NOP && (e_ret.br == BR_NONE || e_ret.op == RET);
               exp_jmp = !sq && e_ret.br == BR_T;
               chk("write_enable", oRAMWriteEnable, exp_we);
               chk("jump_flag", oJumpFlag, exp_jmp);
               if (exp_we) begin
                  chk("write_addr", oRAMWriteAddress, e_ret.dest);
                  chk("write_data", oRAMWriteData, e_ret.data);
               end
               if (exp_jmp) begin
                  chk("jump_ip", oJumpIp, e_ret.dest);
                  squash_upto = seq_ctr;
                  m_flush     = (exp_q.size() != 0);
               end
            end
         end else begin
            chk("idle_we", oRAMWriteEnable, 0);
            chk("idle_jump", oJumpFlag, 0);
         end
         if (exp_q.size() == 0) m_flush = 1'b0;
      end
   end

   task automatic drive(input logic dv, input logic [15:0] op, input logic [15:0] dest,
                        input logic [VW-1:0] s0, input logic [VW-1:0] s1,
                        input int br, input int lat);
      @(posedge Clock);
      #1;
      iDecodeDone  = dv;
      iOperation   = op;
      iDestination = dest;
      iSource0     = s0;
      iSource1     = s1;
      drv_br       = br;
      drv_lat      = lat;
`ifdef EXE_SCOREBOARD_EN
      iSrcAddr0 = 16'($urandom_range(0, 7)) << 4;
      iSrcAddr1 = 16'($urandom_range(0, 7)) << 4;
`endif
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, '0, '0, '0, '0, BR_NONE, 1);
   endtask

   task automatic do_reset();
      @(posedge Clock);
      #1;
      Reset       = 1'b1;
      iDecodeDone = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;
   endtask

   task automatic stray_pulse();
      @(negedge Clock);
      stray = 1'b1;
      @(posedge Clock);
      #2;
      stray = 1'b0;
   endtask

   initial begin
      alu_en    = 1'b1;
      stall_pct = 0;
      do_reset();
      idle(1);

      // Single ADD, three-cycle ALU latency.
      drive(1'b1, ADD, 16'h0020, '0, {32'h1, 32'h2, 32'h3}, BR_NONE, 3);
      idle(6);

      // Back-to-back issue until the window fills.
      for (int i = 0; i < 6; i++)
         drive(1'b1, ADD, 16'h0100 + 16'(i), {3{$urandom}}, {3{$urandom}}, BR_NONE, 4);
      idle(10);

      // Taken jump at the head with two younger ops behind it.
      drive(1'b1, JMP, 16'h0040, {3{$urandom}}, {3{$urandom}}, BR_T, 4);
      drive(1'b1, ADD, 16'h0060, {3{$urandom}}, {3{$urandom}}, BR_NONE, 1);
      drive(1'b1, ADD, 16'h0062, {3{$urandom}}, {3{$urandom}}, BR_NONE, 1);
      idle(10);

      // RET with a taken branch writes and jumps.
      drive(1'b1, RET, 16'h0055, {3{$urandom}}, {3{$urandom}}, BR_T, 2);
      idle(5);

      // NOP and a not-taken jump produce neither write nor redirect.
      drive(1'b1, NOP, 16'h0030, {3{$urandom}}, {3{$urandom}}, BR_NONE, 1);
      drive(1'b1, JMP, 16'h0070, {3{$urandom}}, {3{$urandom}}, BR_NT, 1);
      idle(5);

      // Randomised traffic with ALU back-pressure.
      stall_pct = 25;
      for (int i = 0; i < 1500; i++) begin
         int r, b;
         logic [15:0] op;
         r  = $urandom_range(0, 3);
         op = (r == 0) ? NOP : (r == 1) ? RET : (r == 2) ? ADD : JMP;
         b  = $urandom_range(0, 99);
         drive(($urandom_range(0, 99) < 60), op, 16'($urandom_range(0, 7)) << 4,
               {3{$urandom}}, {3{$urandom}},
               (b < 20) ? BR_T : (b < 40) ? BR_NT : BR_NONE, $urandom_range(1, 4));
      end
      stall_pct = 0;
      idle(30);

      // Reset with ops in flight, then a stale result arrives.
      alu_en = 1'b0;
      drive(1'b1, ADD, 16'h0010, {3{$urandom}}, {3{$urandom}}, BR_NONE, 1);
      drive(1'b1, ADD, 16'h0012, {3{$urandom}}, {3{$urandom}}, BR_NONE, 1);
      idle(1);
      do_reset();
      idle(1);
      stray_pulse();
      idle(3);
      do_reset();
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
